// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: opcodes, instruction-register field layout,
// fetch state encoding and the PC increment.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam int IR_OP_MSB  = 31;
    localparam int IR_OP_LSB  = 24;
    localparam int IR_RD_MSB  = 23;
    localparam int IR_RD_LSB  = 16;
    localparam int IR_RS1_MSB = 15;
    localparam int IR_RS1_LSB = 8;
    localparam int IR_RS2_MSB = 7;
    localparam int IR_RS2_LSB = 0;

    localparam int unsigned PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_next_adder.sv
// Next-PC computation: sequential pc+4 or the pc-relative word-offset target.
module pc_next_adder
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [7:0]        offset,
    input  logic              sel_target,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] pc_plus4_s;
    logic [ADDR_W-1:0] offset_bytes_s;
    logic [ADDR_W-1:0] target_s;

    // Sign-extended word offset is scaled to bytes and added to the sequential PC.
    always_comb begin
        pc_plus4_s     = pc + ADDR_W'(PC_INCR);
        offset_bytes_s = {{(ADDR_W-10){offset[7]}}, offset, 2'b00};
        target_s       = pc_plus4_s + offset_bytes_s;
        if (sel_target) begin
            next_pc = target_s;
        end else begin
            next_pc = pc_plus4_s;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, instruction-memory read handshake, instruction
// register and field decode for control_unit and the datapath.
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              CLK,
    input  logic              RESET_N,
    output logic              imem_read,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [31:0]       imem_instr,
    input  logic              imem_busywait,
    input  logic              stall,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    output logic              instr_valid,
    output logic [7:0]        opcode,
    output logic [7:0]        rd_offset,
    output logic [7:0]        rs1,
    output logic [7:0]        rs2_imm,
    output logic [ADDR_W-1:0] pc
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [ADDR_W-1:0] next_pc_s;
    logic              sel_target_s;

    // Jump and taken branch share one target; jump dominating is implicit.
    assign sel_target_s = jump | (branch & zero);

    pc_next_adder #(.ADDR_W(ADDR_W)) u_pc_next_adder (
        .pc         (pc_q),
        .offset     (ir_q[IR_RD_MSB:IR_RD_LSB]),
        .sel_target (sel_target_s),
        .next_pc    (next_pc_s)
    );

    // State, PC and instruction register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Fetch sequencing; busywait only matters in FETCH, stall only in ISSUE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!imem_busywait) begin
                    ir_d    = imem_instr;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_ISSUE: begin
                if (!stall) begin
                    pc_d    = next_pc_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign imem_read    = (state_q == ST_FETCH);
    assign instr_valid  = (state_q == ST_ISSUE);
    assign imem_address = pc_q;
    assign pc           = pc_q;
    assign opcode       = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign rd_offset    = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign rs1          = ir_q[IR_RS1_MSB:IR_RS1_LSB];
    assign rs2_imm      = ir_q[IR_RS2_MSB:IR_RS2_LSB];

endmodule
